// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared VGA timing definitions for the raster generator and its consumers
// (color_mapper4, sprite/ball/enemy modules).
//   coord_t        : 10-bit pixel coordinate type shared by all video modules.
//   VGA_*          : default 640x480@60 Hz timing, 50 MHz system clock.
//   H_/V_TOTAL, HS_/VS_START/END : derived line/frame geometry.
//   clog2_min1()   : counter width helper that never returns 0.
// ---------------------------------------------------------------------------
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int unsigned VGA_CLK_DIV     = 2;
    localparam int unsigned VGA_H_VISIBLE   = 640;
    localparam int unsigned VGA_H_FRONT     = 16;
    localparam int unsigned VGA_H_SYNC      = 96;
    localparam int unsigned VGA_H_BACK      = 48;
    localparam int unsigned VGA_V_VISIBLE   = 480;
    localparam int unsigned VGA_V_FRONT     = 10;
    localparam int unsigned VGA_V_SYNC      = 2;
    localparam int unsigned VGA_V_BACK      = 33;
    localparam int unsigned VGA_ANIM_FRAMES = 8;

    localparam int unsigned H_TOTAL  = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned V_TOTAL  = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int unsigned HS_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int unsigned HS_END   = HS_START + VGA_H_SYNC;
    localparam int unsigned VS_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int unsigned VS_END   = VS_START + VGA_V_SYNC;

    // Width needed to count 0..n-1; a 1-bit minimum keeps degenerate
    // counters (n = 1 or 2) legal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        if (n <= 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage : vga_pkg

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 on each inc
// strobe and derives the registered sync and active flags from the
// next-state count, so they line up with count in the same cycle.
//   Clk, Reset_n : clock, asynchronous active-low reset.
//   inc          : advance strobe (pix_en for H, h wrap for V).
//   count        : current position, 0..TOTAL-1.
//   wrap         : combinational, high when this edge takes count back to 0.
//   sync_n       : registered, low inside the sync interval.
//   active       : registered, high inside the visible interval.
// ---------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned VISIBLE = 640,
    parameter int unsigned FRONT   = 16,
    parameter int unsigned SYNC    = 96,
    parameter int unsigned BACK    = 48
) (
    input  logic   Clk,
    input  logic   Reset_n,
    input  logic   inc,
    output coord_t count,
    output logic   wrap,
    output logic   sync_n,
    output logic   active
);

    localparam int unsigned TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam coord_t      LAST_C     = coord_t'(TOTAL - 1);
    localparam coord_t      SYNC_LO_C  = coord_t'(VISIBLE + FRONT);
    localparam coord_t      SYNC_HI_C  = coord_t'(VISIBLE + FRONT + SYNC);
    localparam coord_t      VISIBLE_C  = coord_t'(VISIBLE);

    coord_t count_q;
    coord_t count_d;
    logic   sync_n_q;
    logic   sync_n_d;
    logic   active_q;
    logic   active_d;

    // Next position plus the flags that position will carry.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            if (count_q == LAST_C) begin
                count_d = '0;
            end else begin
                count_d = count_q + 10'd1;
            end
        end else begin
            count_d = count_q;
        end
        sync_n_d = ~((count_d >= SYNC_LO_C) && (count_d < SYNC_HI_C));
        active_d = (count_d < VISIBLE_C);
    end

    // Axis state; reset lands on position 0 (visible, sync inactive).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q  <= '0;
            sync_n_q <= 1'b1;
            active_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            sync_n_q <= sync_n_d;
            active_q <= active_d;
        end
    end

    assign count  = count_q;
    assign wrap   = inc && (count_q == LAST_C);
    assign sync_n = sync_n_q;
    assign active = active_q;

endmodule : vga_axis_counter

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 Hz raster timing from the 50 MHz system clock.
//   Clk, Reset_n : system clock, asynchronous active-low reset.
//   DrawX, DrawY : current pixel column / row (0..H_TOTAL-1, 0..V_TOTAL-1).
//   VGA_CLK      : pixel clock to the DAC, rising mid-pixel.
//   VGA_HS/VS    : active-low syncs, aligned with DrawX/DrawY.
//   VGA_BLANK_N  : high only in the visible region.
//   VGA_SYNC_N   : tied low (no sync-on-green).
//   pix_en       : one-Clk strobe; the raster advances on this edge.
//   line_start   : one-Clk pulse in the first cycle of a new line.
//   frame_start  : one-Clk pulse in the first cycle of a new frame.
//   changeFrame  : toggles every ANIM_FRAMES frames for sprite animation.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
    parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT     = VGA_H_FRONT,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BACK      = VGA_H_BACK,
    parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT     = VGA_V_FRONT,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BACK      = VGA_V_BACK,
    parameter int unsigned ANIM_FRAMES = VGA_ANIM_FRAMES
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       pix_en,
    output logic       line_start,
    output logic       frame_start,
    output logic       changeFrame
);

    localparam int unsigned DIV_W  = clog2_min1(CLK_DIV);
    localparam int unsigned ANIM_W = clog2_min1(ANIM_FRAMES);

    localparam logic [DIV_W-1:0]  DIV_LAST_C  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF_C  = DIV_W'(CLK_DIV / 2);
    localparam logic [ANIM_W-1:0] ANIM_LAST_C = ANIM_W'(ANIM_FRAMES - 1);

    logic [DIV_W-1:0]  div_cnt_q;
    logic [DIV_W-1:0]  div_cnt_d;
    logic [ANIM_W-1:0] anim_cnt_q;
    logic [ANIM_W-1:0] anim_cnt_d;
    logic              line_start_q;
    logic              line_start_d;
    logic              frame_start_q;
    logic              frame_start_d;
    logic              change_frame_q;
    logic              change_frame_d;

    coord_t h_count;
    coord_t v_count;
    logic   h_wrap;
    logic   v_wrap;
    logic   h_sync_n;
    logic   v_sync_n;
    logic   h_active;
    logic   v_active;

    // The raster steps on the last Clk of each pixel period.
    assign pix_en = (div_cnt_q == DIV_LAST_C);

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .inc     (pix_en),
        .count   (h_count),
        .wrap    (h_wrap),
        .sync_n  (h_sync_n),
        .active  (h_active)
    );

    // The vertical axis only moves on the edge that ends a line.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .inc     (h_wrap),
        .count   (v_count),
        .wrap    (v_wrap),
        .sync_n  (v_sync_n),
        .active  (v_active)
    );

    // Pixel divider, line/frame strobes and the animation frame counter.
    always_comb begin
        if (div_cnt_q == DIV_LAST_C) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        // v_wrap implies h_wrap, so it marks the (0,0) edge on its own.
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;

        anim_cnt_d     = anim_cnt_q;
        change_frame_d = change_frame_q;
        if (v_wrap) begin
            if (anim_cnt_q == ANIM_LAST_C) begin
                anim_cnt_d     = '0;
                change_frame_d = ~change_frame_q;
            end else begin
                anim_cnt_d     = anim_cnt_q + ANIM_W'(1);
            end
        end else begin
            anim_cnt_d     = anim_cnt_q;
            change_frame_d = change_frame_q;
        end
    end

    // Divider, strobe and animation state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt_q      <= '0;
            anim_cnt_q     <= '0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            change_frame_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            anim_cnt_q     <= anim_cnt_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            change_frame_q <= change_frame_d;
        end
    end

    // Upper half of the pixel period, so the DAC's rising edge is mid-pixel.
    assign VGA_CLK     = (div_cnt_q >= DIV_HALF_C);
    assign DrawX       = h_count;
    assign DrawY       = v_count;
    assign VGA_HS      = h_sync_n;
    assign VGA_VS      = v_sync_n;
    assign VGA_BLANK_N = h_active & v_active;
    assign VGA_SYNC_N  = 1'b0;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign changeFrame = change_frame_q;

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Reduced-geometry bench for vga_timing_gen. Expected outputs come from a
// closed-form model: after n Clk edges since reset release the raster has
// advanced n/CLK_DIV pixels, and every output follows from that pixel index.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned H_VISIBLE   = 20;
    localparam int unsigned H_FRONT     = 3;
    localparam int unsigned H_SYNC      = 5;
    localparam int unsigned H_BACK      = 4;
    localparam int unsigned V_VISIBLE   = 10;
    localparam int unsigned V_FRONT     = 2;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_BACK      = 3;
    localparam int unsigned ANIM_FRAMES = 5;

    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned FRAME_PIX = H_TOTAL * V_TOTAL;
    localparam int unsigned FRAME_CLK = FRAME_PIX * CLK_DIV;

    // {VGA_CLK, HS, VS, BLANK_N, SYNC_N, pix_en, line_start, frame_start, changeFrame}
    localparam logic [8:0] RESET_FLAGS = 9'b0_1_1_1_0_0_0_0_0;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       pix_en;
    logic       line_start;
    logic       frame_start;
    logic       changeFrame;
    logic [8:0] dut_flags;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned n = 0;
    int unsigned fs_first = 0;

    vga_timing_gen #(
        .CLK_DIV     (CLK_DIV),
        .H_VISIBLE   (H_VISIBLE),
        .H_FRONT     (H_FRONT),
        .H_SYNC      (H_SYNC),
        .H_BACK      (H_BACK),
        .V_VISIBLE   (V_VISIBLE),
        .V_FRONT     (V_FRONT),
        .V_SYNC      (V_SYNC),
        .V_BACK      (V_BACK),
        .ANIM_FRAMES (ANIM_FRAMES)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .pix_en      (pix_en),
        .line_start  (line_start),
        .frame_start (frame_start),
        .changeFrame (changeFrame)
    );

    assign dut_flags = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
                        pix_en, line_start, frame_start, changeFrame};

    always #5 Clk = ~Clk;

    // Hard stop in case something wedges the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    function automatic int unsigned m_hc(input int unsigned cyc);
        return (cyc / CLK_DIV) % H_TOTAL;
    endfunction

    function automatic int unsigned m_vc(input int unsigned cyc);
        return ((cyc / CLK_DIV) / H_TOTAL) % V_TOTAL;
    endfunction

    // Expected outputs after cyc Clk edges since reset release.
    task automatic model(input int unsigned cyc, output logic [9:0] ex,
                         output logic [9:0] ey, output logic [8:0] ef);
        int unsigned d;
        int unsigned p;
        int unsigned hc;
        int unsigned vc;
        int unsigned fr;
        logic        new_px;
        logic        hs;
        logic        vs;
        logic        bl;
        d      = cyc % CLK_DIV;
        p      = cyc / CLK_DIV;
        hc     = p % H_TOTAL;
        vc     = (p / H_TOTAL) % V_TOTAL;
        fr     = p / FRAME_PIX;
        new_px = (cyc > 0) && (d == 0);
        hs     = !((hc >= H_VISIBLE + H_FRONT) && (hc < H_VISIBLE + H_FRONT + H_SYNC));
        vs     = !((vc >= V_VISIBLE + V_FRONT) && (vc < V_VISIBLE + V_FRONT + V_SYNC));
        bl     = (hc < H_VISIBLE) && (vc < V_VISIBLE);
        ex     = 10'(hc);
        ey     = 10'(vc);
        ef     = {(d >= CLK_DIV / 2), hs, vs, bl, 1'b0, (d == CLK_DIV - 1),
                  (new_px && hc == 0), (new_px && (p % FRAME_PIX) == 0),
                  ((fr / ANIM_FRAMES) % 2) == 1};
    endtask

    // Check the current cycle (called at a negedge), then advance one Clk.
    task automatic step();
        logic [9:0] ex;
        logic [9:0] ey;
        logic [8:0] ef;
        model(n, ex, ey, ef);
        chk("DrawX", 32'(DrawX), 32'(ex));
        chk("DrawY", 32'(DrawY), 32'(ey));
        chk("flags", 32'(dut_flags), 32'(ef));
        if (ex == 10'(H_VISIBLE - 1) && ey == 10'(V_VISIBLE - 1)) begin
            chk("corner_last_visible_blank_n", 32'(VGA_BLANK_N), 32'd1);
        end
        if (ex == 10'(H_VISIBLE) && ey == 10'(V_VISIBLE - 1)) begin
            chk("corner_first_blank_blank_n", 32'(VGA_BLANK_N), 32'd0);
        end
        if (n > 0 && (n % CLK_DIV) == 0 && ex == 10'd0 && ey == 10'd0) begin
            chk("wrap_origin_blank_n", 32'(VGA_BLANK_N), 32'd1);
        end
        if (frame_start === 1'b1 && fs_first == 0) begin
            fs_first = n;
        end
        @(posedge Clk);
        n++;
        @(negedge Clk);
    endtask

    task automatic run(input int unsigned cycles);
        for (int i = 0; i < int'(cycles); i++) begin
            step();
        end
    endtask

    // Assert reset between Clk edges, check it took effect asynchronously,
    // hold it across hold_cycles edges, then release at a negedge.
    task automatic async_reset(input int unsigned offs, input int unsigned hold_cycles);
        #(offs);
        Reset_n = 1'b0;
        #1;
        chk("async_rst_xy", 32'({DrawY, DrawX}), 32'd0);
        chk("async_rst_flags", 32'(dut_flags), 32'(RESET_FLAGS));
        repeat (hold_cycles) @(negedge Clk);
        chk("held_rst_xy", 32'({DrawY, DrawX}), 32'd0);
        chk("held_rst_flags", 32'(dut_flags), 32'(RESET_FLAGS));
        Reset_n  = 1'b1;
        n        = 0;
        fs_first = 0;
    endtask

    initial begin
        bit hit;

        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_xy", 32'({DrawY, DrawX}), 32'd0);
        chk("reset_flags", 32'(dut_flags), 32'(RESET_FLAGS));

        // Full frames from reset: first frame_start timing and two
        // changeFrame toggles (after frames 5 and 10).
        Reset_n  = 1'b1;
        n        = 0;
        fs_first = 0;
        run(2 * FRAME_CLK + 5);
        chk("first_frame_start_clk", fs_first, FRAME_CLK);
        run(9 * FRAME_CLK);

        // Reset in the middle of horizontal sync.
        hit = 1'b0;
        for (int i = 0; i < int'(2 * FRAME_CLK) && !hit; i++) begin
            if (m_hc(n) == H_VISIBLE + H_FRONT + 2 && m_vc(n) == V_VISIBLE / 2) begin
                hit = 1'b1;
            end else begin
                step();
            end
        end
        chk("seek_mid_hs", 32'(hit), 32'd1);
        chk("hs_low_before_rst", 32'(VGA_HS), 32'd0);
        async_reset(2, 2);
        run(FRAME_CLK + 5);
        chk("frame_start_after_mid_hs_rst", fs_first, FRAME_CLK);

        // Random run lengths, reset phase and reset width.
        for (int k = 0; k < 6; k++) begin
            run($urandom_range(1, 2 * FRAME_CLK));
            async_reset($urandom_range(1, 3), $urandom_range(1, 3));
            run(FRAME_CLK + 3);
            chk("frame_start_after_rand_rst", fs_first, FRAME_CLK);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vga_timing_gen
